// File: rtl/display_pkg.sv
// Shared display types: FSM state encoding, BCD digit type and field sizes.
package display_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;
endpackage

// File: rtl/bcd_add3_stage.sv
// Add-3 correction for a packed BCD field: every nibble >= 5 gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_stage
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [BCD_W-1:0] o_bcd
);
  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    logic [3:0] w_nib;
    assign w_nib = i_bcd[4*g +: 4];
    assign o_bcd[4*g +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
  end
endmodule

// File: rtl/distance_bcd_sequencer.sv
// Once-per-frame binary-to-BCD converter for the distance display. A v_sync
// rising edge starts a shift-and-add-3 conversion; the three digits and the
// leading-zero blank mask are committed together in a single edge.
module distance_bcd_sequencer
  import display_pkg::*;
#(
  parameter int VALUE_W   = 12,
  parameter int MAX_SHOWN = 999,
  parameter int BLANK_LZ  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_v_sync,
  input  logic [VALUE_W-1:0] i_value,
  output logic [3:0]         o_hundreds,
  output logic [3:0]         o_tens,
  output logic [3:0]         o_ones,
  output logic [2:0]         o_blank,
  output logic               o_busy,
  output logic               o_valid
);
  localparam int CNT_W = $clog2(VALUE_W);
  localparam int SR_W  = BCD_W + VALUE_W;
  localparam logic [2:0] BLANK_RST = (BLANK_LZ != 0) ? 3'b110 : 3'b000;

  state_t             r_state, w_next;
  logic               r_vs_q, r_pending, r_valid;
  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  bcd_digit_t         r_hund, r_tens, r_ones;
  logic [2:0]         r_blank;

  logic               w_req;
  logic [VALUE_W-1:0] w_sat;
  logic [BCD_W-1:0]   w_bcd_fix;
  logic [SR_W-1:0]    w_sr_fix;
  bcd_digit_t         w_h, w_t, w_o;

  assign w_req    = i_v_sync & ~r_vs_q;
  assign w_sat    = (i_value > VALUE_W'(MAX_SHOWN)) ? VALUE_W'(MAX_SHOWN) : i_value;
  assign w_sr_fix = {w_bcd_fix, r_sr[VALUE_W-1:0]};
  assign w_h      = r_sr[SR_W-1 -: 4];
  assign w_t      = r_sr[SR_W-5 -: 4];
  assign w_o      = r_sr[SR_W-9 -: 4];

  bcd_add3_stage u_add3 (
    .i_bcd (r_sr[SR_W-1 -: BCD_W]),
    .o_bcd (w_bcd_fix)
  );

  // State register and v_sync edge history
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_vs_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vs_q  <= i_v_sync;
    end
  end

  // Next-state decode; a request arriving during COMMIT is taken directly
  always_comb begin
    w_next = r_state;
    o_busy = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (w_req) w_next = S_LOAD;
      S_LOAD:   w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == CNT_W'(VALUE_W - 1)) w_next = S_COMMIT;
      S_COMMIT: w_next = (r_pending || w_req) ? S_LOAD : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // One-deep request latch: further requests while busy are absorbed
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                           r_pending <= 1'b0;
    else if (r_state == S_COMMIT)           r_pending <= 1'b0;
    else if (w_req && r_state != S_IDLE)    r_pending <= 1'b1;
  end

  // Conversion datapath: load saturated value, then add-3 and shift each cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_sr  <= {{BCD_W{1'b0}}, w_sat};
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sr  <= w_sr_fix << 1;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Atomic commit of digits and blank mask, plus the visibility pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hund  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_blank <= BLANK_RST;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        r_hund  <= w_h;
        r_tens  <= w_t;
        r_ones  <= w_o;
        r_blank <= (BLANK_LZ != 0) ?
                   {(w_h == 4'd0), (w_h == 4'd0 && w_t == 4'd0), 1'b0} : 3'b000;
      end
    end
  end

  assign o_hundreds = r_hund;
  assign o_tens     = r_tens;
  assign o_ones     = r_ones;
  assign o_blank    = r_blank;
  assign o_valid    = r_valid;
endmodule

// File: tb/tb_distance_bcd_sequencer.sv
// Directed + random bench for distance_bcd_sequencer. Expected digits come
// from decimal arithmetic on the saturated value, not from a shift model.
module tb_distance_bcd_sequencer;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_v_sync = 1'b0;
  logic [11:0] i_value = '0;
  logic [3:0]  o_hundreds, o_tens, o_ones;
  logic [2:0]  o_blank;
  logic        o_busy, o_valid;

  int total = 0;
  int bad   = 0;

  // reference model of the committed display
  int m_h = 0, m_t = 0, m_o = 0;
  logic [2:0] m_blank = 3'b110;

  distance_bcd_sequencer #(.VALUE_W(12), .MAX_SHOWN(999), .BLANK_LZ(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_v_sync(i_v_sync), .i_value(i_value),
    .o_hundreds(o_hundreds), .o_tens(o_tens), .o_ones(o_ones),
    .o_blank(o_blank), .o_busy(o_busy), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_set(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    m_h = s / 100;
    m_t = (s / 10) % 10;
    m_o = s % 10;
    m_blank = {(m_h == 0), (m_h == 0 && m_t == 0), 1'b0};
  endtask

  task automatic chk_display(input string tag);
    chk({tag, ".hund"},  int'(o_hundreds), m_h);
    chk({tag, ".tens"},  int'(o_tens),     m_t);
    chk({tag, ".ones"},  int'(o_ones),     m_o);
    chk({tag, ".blank"}, int'(o_blank),    int'(m_blank));
  endtask

  // one request, bounded wait for the commit pulse, then check digits
  task automatic convert(input string tag, input int v);
    int seen;
    seen = 0;
    i_value  = 12'(v);
    i_v_sync = 1'b1;
    tick();
    i_v_sync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_valid) begin seen = 1; break; end
    end
    chk({tag, ".valid_seen"}, seen, 1);
    model_set(v);
    chk_display(tag);
    repeat (3) tick();
  endtask

  initial begin
    // 1: reset, no v_sync
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();
    chk_display("reset");
    chk("reset.busy", int'(o_busy), 0);
    begin
      int vcnt;
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin tick(); vcnt += int'(o_valid); end
      chk("idle.no_valid", vcnt, 0);
    end

    // 2: exact latency for 347
    i_value = 12'd347;
    i_v_sync = 1'b1;                       // cycle N
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 2) i_v_sync = 1'b0;
      if (t == 15) model_set(347);
      chk($sformatf("lat.busy@%0d", t), int'(o_busy), (t <= 14) ? 1 : 0);
      chk($sformatf("lat.valid@%0d", t), int'(o_valid), (t == 15) ? 1 : 0);
      if (t == 14 || t == 15 || t == 17) chk_display($sformatf("lat.disp@%0d", t));
    end
    repeat (3) tick();

    // 3,4: saturation and blanking corner values
    convert("sat1500", 1500);
    convert("sat4095", 4095);
    convert("v7", 7);
    convert("v40", 40);
    convert("v100", 100);
    convert("v999", 999);
    convert("v1000", 1000);
    convert("v0", 0);

    // 5: pending request, re-sample, extra request absorbed
    i_value = 12'd347;
    i_v_sync = 1'b1;                       // cycle N
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (t == 15) model_set(347);
      if (t == 29) model_set(12);
      chk($sformatf("pend.valid@%0d", t), int'(o_valid), (t == 15 || t == 29) ? 1 : 0);
      if (t == 15 || t == 28 || t == 29 || t == 45) chk_display($sformatf("pend.disp@%0d", t));
      case (t)
        2: i_v_sync = 1'b0;
        5: begin i_v_sync = 1'b1; i_value = 12'd12; end
        6: i_v_sync = 1'b0;
        8: i_v_sync = 1'b1;
        9: i_v_sync = 1'b0;
        default: ;
      endcase
    end

    // 6: reset mid-conversion
    i_value = 12'd555;
    i_v_sync = 1'b1;                       // cycle N
    begin
      int vcnt;
      vcnt = 0;
      for (int t = 1; t <= 25; t++) begin
        tick();
        vcnt += int'(o_valid);
        if (t == 2) i_v_sync = 1'b0;
        if (t == 7) i_rst_n = 1'b0;
        if (t == 8) begin
          i_rst_n = 1'b1;
          m_h = 0; m_t = 0; m_o = 0; m_blank = 3'b110;
          chk("rst.busy", int'(o_busy), 0);
          chk_display("rst.disp");
        end
      end
      chk("rst.no_valid", vcnt, 0);
      chk_display("rst.hold");
    end
    convert("after_rst", 865);

    // random values against the decimal model
    for (int i = 0; i < 24; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(990, 1010)) : int'($urandom_range(0, 4095));
      convert($sformatf("rnd%0d_%0d", i, v), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
